// File: rtl/push_btn_poller_pkg.sv
// Shared definitions for the push-button poller: button-block opcodes,
// poller opcodes, FSM state encoding and small decode helpers.
package push_btn_poller_pkg;

  // Opcodes understood by the push-button blocks
  localparam logic [3:0] BTN_OP_NOP = 4'h0;
  localparam logic [3:0] BTN_OP_RBS = 4'h1;

  // Opcodes understood by the poller itself (4..F are illegal)
  localparam logic [3:0] POLL_OP_NOP = 4'h0;
  localparam logic [3:0] POLL_OP_RUN = 4'h1;
  localparam logic [3:0] POLL_OP_HLT = 4'h2;
  localparam logic [3:0] POLL_OP_ONE = 4'h3;

  // Instruction word sent to a button block to read its status
  localparam logic [11:0] RBS_WORD = {BTN_OP_RBS, 8'h00};
  localparam logic [11:0] NOP_WORD = {BTN_OP_NOP, 8'h00};

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_REPORT = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // One-hot select of button block idx
  function automatic logic [3:0] btn_onehot(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b0001;
    return sel << idx;
  endfunction

  // Six-character ASCII name of a state, for waveform debug
  function automatic logic [47:0] state_name(input state_t st);
    logic [47:0] name;
    case (st)
      ST_RESET:  name = "RESET ";
      ST_IDLE:   name = "IDLE  ";
      ST_WAIT:   name = "WAIT  ";
      ST_ISSUE:  name = "ISSUE ";
      ST_SAMPLE: name = "SAMPLE";
      ST_REPORT: name = "REPORT";
      ST_ERROR:  name = "ERROR ";
      default:   name = "??????";
    endcase
    return name;
  endfunction

  // Three-character ASCII name of a poller opcode, for waveform debug
  function automatic logic [23:0] op_name(input logic [3:0] op);
    logic [23:0] name;
    case (op)
      POLL_OP_NOP: name = "NOP";
      POLL_OP_RUN: name = "RUN";
      POLL_OP_HLT: name = "HLT";
      POLL_OP_ONE: name = "ONE";
      default:     name = "ERR";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/push_btn_poller_timer.sv
// Wait-interval counter: loads a start value, counts down to zero and
// holds there, flagging zero from a register.
module poll_timer #(
  parameter int PollSize = 17
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                dec,
  input  logic [PollSize-1:0] load_value,
  output logic                zero
);

  logic [PollSize-1:0] count;

  // Countdown register with load priority over decrement
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= {PollSize{1'b0}};
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_value;
      zero  <= (load_value == {PollSize{1'b0}});
    end else if (dec && !zero) begin
      count <= count - PollSize'(1);
      zero  <= (count == PollSize'(1));
    end else begin
      count <= count;
      zero  <= zero;
    end
  end

endmodule

// File: rtl/push_btn_poller.sv
// Push-button poller: sweeps four push-button blocks with RBS reads,
// collects which were pressed and reports them with a valid/ready event,
// either once or periodically with a programmable idle gap.
module push_btn_poller
  import push_btn_poller_pkg::*;
#(
  parameter int PollWait = 100000,
  parameter int PollSize = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [11:0] btn_inst,
  output logic [3:0]  btn_inst_en,
  input  logic [3:0]  btn_status,
  output logic        evt_valid,
  output logic [3:0]  evt_mask,
  input  logic        evt_ready
);

  state_t      state;
  state_t      state_next;
  logic        run;
  logic        run_next;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [3:0]  acc;
  logic [3:0]  acc_next;
  logic [3:0]  acc_capture;
  logic [3:0]  opcode;
  logic        run_cmd;
  logic        hlt_cmd;
  logic        one_cmd;
  logic        bad_cmd;
  logic        timer_load;
  logic        timer_dec;
  logic        timer_zero;
  logic [47:0] dbg_state;
  logic [47:0] dbg_state_next;
  logic [23:0] dbg_opcode;
  logic        unused_bits;

  assign opcode  = inst[11:8];
  assign run_cmd = inst_en && (opcode == POLL_OP_RUN);
  assign hlt_cmd = inst_en && (opcode == POLL_OP_HLT);
  assign one_cmd = inst_en && (opcode == POLL_OP_ONE);
  assign bad_cmd = inst_en && (opcode > POLL_OP_ONE);

  // Accumulator with the bit of the block being sampled replaced by its status
  always_comb begin
    acc_capture      = acc;
    acc_capture[idx] = btn_status[idx];
  end

  // Next-state, run-flag, index and accumulator decisions
  always_comb begin
    state_next = state;
    run_next   = run;
    idx_next   = idx;
    acc_next   = acc;
    case (state)
      ST_RESET: begin
        state_next = ST_IDLE;
        run_next   = 1'b0;
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
        run_next   = 1'b0;
      end
      ST_IDLE, ST_WAIT, ST_ISSUE, ST_SAMPLE, ST_REPORT: begin
        if (bad_cmd) begin
          state_next = ST_ERROR;
          run_next   = 1'b0;
        end else begin
          if (run_cmd) begin
            run_next = 1'b1;
          end else if (hlt_cmd) begin
            run_next = 1'b0;
          end else begin
            run_next = run;
          end
          case (state)
            ST_IDLE: begin
              if (run_cmd || one_cmd) begin
                state_next = ST_ISSUE;
                idx_next   = 2'd0;
                acc_next   = 4'h0;
              end else begin
                state_next = ST_IDLE;
              end
            end
            ST_WAIT: begin
              if (hlt_cmd) begin
                state_next = ST_IDLE;
              end else if (timer_zero) begin
                state_next = ST_ISSUE;
                idx_next   = 2'd0;
                acc_next   = 4'h0;
              end else begin
                state_next = ST_WAIT;
              end
            end
            ST_ISSUE: begin
              state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
              acc_next = acc_capture;
              if (idx != 2'd3) begin
                state_next = ST_ISSUE;
                idx_next   = idx + 2'd1;
              end else if (acc_capture != 4'h0) begin
                state_next = ST_REPORT;
              end else if (run_next) begin
                state_next = ST_WAIT;
              end else begin
                state_next = ST_IDLE;
              end
            end
            ST_REPORT: begin
              if (evt_ready) begin
                state_next = run_next ? ST_WAIT : ST_IDLE;
              end else begin
                state_next = ST_REPORT;
              end
            end
            default: begin
              state_next = ST_ERROR;
            end
          endcase
        end
      end
      default: begin
        state_next = ST_ERROR;
        run_next   = 1'b0;
      end
    endcase
  end

  assign timer_load = (state_next == ST_WAIT) && (state != ST_WAIT);
  assign timer_dec  = (state == ST_WAIT);

  poll_timer #(
    .PollSize (PollSize)
  ) u_poll_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (PollSize'(PollWait - 1)),
    .zero       (timer_zero)
  );

  // State registers and outputs registered from the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RESET;
      run         <= 1'b0;
      idx         <= 2'd0;
      acc         <= 4'h0;
      btn_inst    <= 12'h000;
      btn_inst_en <= 4'h0;
      evt_valid   <= 1'b0;
      evt_mask    <= 4'h0;
    end else begin
      state       <= state_next;
      run         <= run_next;
      idx         <= idx_next;
      acc         <= acc_next;
      btn_inst    <= (state_next == ST_ISSUE) ? RBS_WORD : NOP_WORD;
      btn_inst_en <= (state_next == ST_ISSUE) ? btn_onehot(idx_next) : 4'h0;
      evt_valid   <= (state_next == ST_REPORT);
      evt_mask    <= (state_next == ST_REPORT) ? acc_next : 4'h0;
    end
  end

  // ASCII decodes of current/next state and incoming opcode for waveforms
  always_comb begin
    dbg_state      = state_name(state);
    dbg_state_next = state_name(state_next);
    dbg_opcode     = op_name(opcode);
  end

  // Debug decodes and the ignored operand byte have no functional sink
  assign unused_bits = ^{dbg_state, dbg_state_next, dbg_opcode, inst[7:0]};

endmodule
